// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared definitions for the RV32I decode stage.
//   XLEN / ADDR_SIZE : default datapath and register-address widths
//   opcode_e         : RV32I base opcodes (instr[6:0])
//   decode_state_e   : decode FSM state encoding
//   dec_info_t       : per-opcode source/destination usage
//   decode_opcode()  : opcode -> dec_info_t lookup
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 5;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_OP_IMM   = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [1:0] {
        DEC_EMPTY  = 2'd0,
        DEC_CHECK  = 2'd1,
        DEC_ISSUED = 2'd2
    } decode_state_e;

    typedef struct packed {
        logic legal;
        logic use_rs1;
        logic use_rs2;
        logic writes_rd;
    } dec_info_t;

    function automatic dec_info_t decode_opcode(input logic [6:0] opcode);
        dec_info_t info;
        info = '0;
        case (opcode_e'(opcode))
            OP_OP:       info = '{legal: 1'b1, use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b1};
            OP_STORE,
            OP_BRANCH:   info = '{legal: 1'b1, use_rs1: 1'b1, use_rs2: 1'b1, writes_rd: 1'b0};
            OP_OP_IMM,
            OP_LOAD,
            OP_JALR:     info = '{legal: 1'b1, use_rs1: 1'b1, use_rs2: 1'b0, writes_rd: 1'b1};
            OP_LUI,
            OP_AUIPC,
            OP_JAL:      info = '{legal: 1'b1, use_rs1: 1'b0, use_rs2: 1'b0, writes_rd: 1'b1};
            OP_SYSTEM,
            OP_MISC_MEM: info = '{legal: 1'b1, use_rs1: 1'b0, use_rs2: 1'b0, writes_rd: 1'b0};
            default:     info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen -- combinational RV32I immediate generator.
//   instr : 32-bit instruction word
//   imm   : sign-extended immediate (I/S/B/U/J); 0 for R-type and
//           for opcodes outside the base set
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = 32'h0;
        case (opcode_e'(instr[6:0]))
            OP_OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr[31:12], 12'h000};
            OP_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = 32'h0;
        endcase
    end

    // Signed size cast sign-extends when XLEN is wider than 32.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage -- single-entry RV32I decode stage with register-file read
// request and optional register scoreboard.
//
// Build option: DECODE_SCOREBOARD_EN
//   defined   : 32 busy bits; sources busy in the scoreboard stall CHECK
//   undefined : no scoreboard, never stalls, wb_en/wb_addr ignored
//
// Ports
//   clk, rst                 clock, async active-high reset
//   flush                    discard held instruction (sync)
//   if_valid/if_ready        fetch handshake
//   if_instr/if_pc           instruction word and its PC
//   read_en1/2, read_addr1/2 register file read request
//   wb_en/wb_addr            writeback commit (clears busy bit)
//   id_valid/id_ready        execute handshake
//   id_instr/id_pc           held instruction and PC
//   id_rd                    destination, 0 if none written
//   id_imm                   sign-extended immediate
//   id_illegal               held opcode outside RV32I
//
// state  | meaning
// EMPTY  | nothing held, ready for fetch
// CHECK  | instruction held, waiting for sources to be free; reads issued
// ISSUED | decoded instruction and read data presented to execute
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int ADDR_SIZE = riscv_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [31:0]          if_instr,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 read_en1,
    output logic                 read_en2,
    output logic [ADDR_SIZE-1:0] read_addr1,
    output logic [ADDR_SIZE-1:0] read_addr2,
    input  logic                 wb_en,
    input  logic [ADDR_SIZE-1:0] wb_addr,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [31:0]          id_instr,
    output logic [XLEN-1:0]      id_pc,
    output logic [ADDR_SIZE-1:0] id_rd,
    output logic [XLEN-1:0]      id_imm,
    output logic                 id_illegal
);

    localparam logic [1:0] S_EMPTY  = DEC_EMPTY;
    localparam logic [1:0] S_CHECK  = DEC_CHECK;
    localparam logic [1:0] S_ISSUED = DEC_ISSUED;

    logic [1:0]           state, state_nxt;
    logic [31:0]          instr_q;
    logic [XLEN-1:0]      pc_q;
    dec_info_t            info;
    logic [ADDR_SIZE-1:0] rs1, rs2, rd;
    logic                 capture;
    logic                 hazard;
    logic                 issue;
    logic                 in_check;

    assign info     = decode_opcode(instr_q[6:0]);
    assign rd       = instr_q[11:7];
    assign rs1      = instr_q[19:15];
    assign rs2      = instr_q[24:20];
    assign in_check = (state == S_CHECK);

    assign if_ready = (state == S_EMPTY) || ((state == S_ISSUED) && id_ready);
    assign capture  = if_valid && if_ready && !flush;
    // Flushed instructions never reach ISSUED, so they never mark rd busy.
    assign issue    = in_check && !hazard && !flush;

`ifdef DECODE_SCOREBOARD_EN
    localparam int NREGS = 1 << ADDR_SIZE;

    logic [NREGS-1:0] busy_q, busy_nxt;

    // Sources read as x0 never stall; x0 is never marked busy anyway.
    assign hazard = (info.use_rs1 && (rs1 != '0) && busy_q[rs1]) ||
                    (info.use_rs2 && (rs2 != '0) && busy_q[rs2]);

    always_comb begin
        busy_nxt = busy_q;
        if (wb_en && (wb_addr != '0))
            busy_nxt[wb_addr] = 1'b0;
        // Set after clear so a same-edge set of the same register wins.
        if (issue && info.writes_rd && (rd != '0))
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = ^{wb_en, wb_addr};
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY:  if (capture) state_nxt = S_CHECK;
            S_CHECK:  if (!hazard) state_nxt = S_ISSUED;
            S_ISSUED: if (id_ready) state_nxt = capture ? S_CHECK : S_EMPTY;
            default:  state_nxt = S_EMPTY;
        endcase
        if (flush)
            state_nxt = S_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_EMPTY;
            instr_q <= 32'h0;
            pc_q    <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                instr_q <= if_instr;
                pc_q    <= if_pc;
            end
        end
    end

    assign read_en1   = issue && info.use_rs1;
    assign read_en2   = issue && info.use_rs2;
    assign read_addr1 = rs1;
    assign read_addr2 = rs2;

    assign id_valid   = (state == S_ISSUED);
    assign id_illegal = id_valid && !info.legal;
    assign id_instr   = instr_q;
    assign id_pc      = pc_q;
    assign id_rd      = info.writes_rd ? rd : '0;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instr_q),
        .imm   (id_imm)
    );

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        read_en1;
    logic        read_en2;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic        id_illegal;

    int checks   = 0;
    int failures = 0;

    decode_stage #(
        .XLEN      (32),
        .ADDR_SIZE (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .read_en1   (read_en1),
        .read_en2   (read_en2),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_rd      (id_rd),
        .id_imm     (id_imm),
        .id_illegal (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'h0;
        if_pc    = 32'h0;
        wb_en    = 1'b0;
        wb_addr  = 5'd0;
        id_ready = 1'b1;

        #3;
        chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_read_en1", {31'b0, read_en1}, 32'd0);
        chk("rst_id_imm", id_imm, 32'h0);
        chk("rst_id_rd", {27'b0, id_rd}, 32'd0);
        chk("rst_id_illegal", {31'b0, id_illegal}, 32'd0);

        // addi x1,x0,5
        #9;
        rst      = 1'b0;
        if_valid = 1'b1;
        if_instr = 32'h00500093;
        if_pc    = 32'h00000100;
        tick();
        if_valid = 1'b0;
        chk("addi_check_re1", {31'b0, read_en1}, 32'd1);
        chk("addi_check_ra1", {27'b0, read_addr1}, 32'd0);
        chk("addi_check_re2", {31'b0, read_en2}, 32'd0);
        chk("addi_check_valid", {31'b0, id_valid}, 32'd0);
        chk("addi_check_ifrdy", {31'b0, if_ready}, 32'd0);
        tick();
        chk("addi_iss_valid", {31'b0, id_valid}, 32'd1);
        chk("addi_iss_rd", {27'b0, id_rd}, 32'd1);
        chk("addi_iss_imm", id_imm, 32'd5);
        chk("addi_iss_pc", id_pc, 32'h00000100);
        chk("addi_iss_instr", id_instr, 32'h00500093);
        chk("addi_iss_illegal", {31'b0, id_illegal}, 32'd0);
        chk("addi_iss_ifrdy", {31'b0, if_ready}, 32'd1);

        // add x2,x1,x1 captured on the same edge that retires the addi
        if_valid = 1'b1;
        if_instr = 32'h00108133;
        if_pc    = 32'h00000104;
        tick();
        if_valid = 1'b0;
`ifdef DECODE_SCOREBOARD_EN
        chk("add_haz_re1", {31'b0, read_en1}, 32'd0);
        chk("add_haz_re2", {31'b0, read_en2}, 32'd0);
        tick();
        chk("add_haz2_re1", {31'b0, read_en1}, 32'd0);
        chk("add_haz2_valid", {31'b0, id_valid}, 32'd0);
        wb_en   = 1'b1;
        wb_addr = 5'd1;
        #1;
        chk("add_nobypass_re1", {31'b0, read_en1}, 32'd0);
        tick();
        wb_en   = 1'b0;
        wb_addr = 5'd0;
`endif
        chk("add_rel_re1", {31'b0, read_en1}, 32'd1);
        chk("add_rel_re2", {31'b0, read_en2}, 32'd1);
        chk("add_rel_ra1", {27'b0, read_addr1}, 32'd1);
        chk("add_rel_ra2", {27'b0, read_addr2}, 32'd1);
        chk("add_rel_valid", {31'b0, id_valid}, 32'd0);
        tick();
        chk("add_iss_valid", {31'b0, id_valid}, 32'd1);
        chk("add_iss_rd", {27'b0, id_rd}, 32'd2);
        chk("add_iss_imm", id_imm, 32'h0);
        tick();
        chk("drain_valid", {31'b0, id_valid}, 32'd0);
        chk("drain_ifrdy", {31'b0, if_ready}, 32'd1);

        // beq x0,x0,-4 with execute stalled for one cycle
        if_valid = 1'b1;
        if_instr = 32'hFE000EE3;
        if_pc    = 32'h00000200;
        tick();
        if_valid = 1'b0;
        id_ready = 1'b0;
        chk("beq_check_re1", {31'b0, read_en1}, 32'd1);
        chk("beq_check_re2", {31'b0, read_en2}, 32'd1);
        tick();
        chk("beq_iss_valid", {31'b0, id_valid}, 32'd1);
        chk("beq_iss_ifrdy", {31'b0, if_ready}, 32'd0);
        chk("beq_iss_imm", id_imm, 32'hFFFFFFFC);
        chk("beq_iss_rd", {27'b0, id_rd}, 32'd0);
        tick();
        chk("beq_hold_valid", {31'b0, id_valid}, 32'd1);

        // illegal word offered as execute accepts the beq
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'hFFFFFFFF;
        if_pc    = 32'h00000204;
        #1;
        chk("ill_offer_ifrdy", {31'b0, if_ready}, 32'd1);
        tick();
        if_valid = 1'b0;
        chk("ill_check_re1", {31'b0, read_en1}, 32'd0);
        chk("ill_check_re2", {31'b0, read_en2}, 32'd0);
        tick();
        chk("ill_iss_illegal", {31'b0, id_illegal}, 32'd1);
        chk("ill_iss_valid", {31'b0, id_valid}, 32'd1);
        chk("ill_iss_rd", {27'b0, id_rd}, 32'd0);
        chk("ill_iss_imm", id_imm, 32'h0);

        // add x4,x2,x0 then flushed while in CHECK
        if_valid = 1'b1;
        if_instr = 32'h00010233;
        if_pc    = 32'h00000208;
        tick();
        if_valid = 1'b0;
`ifdef DECODE_SCOREBOARD_EN
        chk("x2busy_re1", {31'b0, read_en1}, 32'd0);
`else
        chk("x2busy_re1", {31'b0, read_en1}, 32'd1);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_ifrdy", {31'b0, if_ready}, 32'd1);
        chk("flush_re1", {31'b0, read_en1}, 32'd0);

        // add x5,x4,x0: x4 was never marked busy by the flushed add
        if_valid = 1'b1;
        if_instr = 32'h000202B3;
        if_pc    = 32'h0000020C;
        tick();
        if_valid = 1'b0;
        id_ready = 1'b0;
        chk("x4free_re1", {31'b0, read_en1}, 32'd1);
        tick();
        chk("x5_iss_valid", {31'b0, id_valid}, 32'd1);
        chk("x5_iss_rd", {27'b0, id_rd}, 32'd5);

        // asynchronous reset while ISSUED and stalled
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, id_valid}, 32'd0);
        chk("midrst_ifrdy", {31'b0, if_ready}, 32'd1);
        chk("midrst_rd", {27'b0, id_rd}, 32'd0);
        chk("midrst_pc", id_pc, 32'h0);
        chk("midrst_instr", id_instr, 32'h0);
        rst      = 1'b0;
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h002101B3;
        if_pc    = 32'h00000300;

        // add x3,x2,x2: x2 busy bit cleared by reset
        tick();
        if_valid = 1'b0;
        chk("postrst_re1", {31'b0, read_en1}, 32'd1);
        chk("postrst_re2", {31'b0, read_en2}, 32'd1);
        tick();
        chk("postrst_valid", {31'b0, id_valid}, 32'd1);
        chk("postrst_rd", {27'b0, id_rd}, 32'd3);
        chk("postrst_pc", id_pc, 32'h00000300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
